// File: rtl/c5_mem_mux.sv
`default_nettype none
// ============================================================================
// c5_mem_mux : runs the arbiter's granted client command on the shared memory
//              port, one transaction at a time, with a read-response timeout.
// Revision   : 1.0
// ============================================================================
module c5_mem_mux #(
  parameter int WIDTH   = 6,
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic [WIDTH-1:0]        I_grant,
  output logic                    O_stall,
  input  logic [WIDTH*AW-1:0]     I_addr,
  input  logic [WIDTH-1:0]        I_we,
  input  logic [WIDTH*DW-1:0]     I_wdata,
  input  logic [WIDTH*DW/8-1:0]   I_be,
  output logic [WIDTH-1:0]        O_ack,
  output logic                    O_err,
  output logic [DW-1:0]           O_rdata,
  output logic                    O_mem_req,
  output logic                    O_mem_we,
  output logic [AW-1:0]           O_mem_addr,
  output logic [DW-1:0]           O_mem_wdata,
  output logic [DW/8-1:0]         O_mem_be,
  input  logic                    I_mem_ready,
  input  logic                    I_mem_valid,
  input  logic [DW-1:0]           I_mem_rdata
);

  localparam int c_bw = DW / 8;
  localparam int c_iw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_cw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cw-1:0] c_tmo_last = c_cw'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t            r_state;
  logic [c_iw-1:0]   r_idx;
  logic [c_cw-1:0]   r_cnt;
  logic [c_iw-1:0]   w_idx;
  logic [WIDTH-1:0]  w_hot;
  logic              w_timeout;

  // Multi-hot grants resolve to the lowest index: scan from the top down.
  always_comb begin
    w_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (I_grant[i]) begin
        w_idx = c_iw'(i);
      end
    end
  end

  assign w_hot     = WIDTH'(1) << r_idx;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_tmo_last);

  // Combinational so the arbiter freezes its grant on the very edge we latch it.
  assign O_stall = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_ACK) ||
                   ((r_state == ST_IDLE) && (|I_grant));

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      O_ack       <= '0;
      O_err       <= 1'b0;
      O_rdata     <= '0;
      O_mem_req   <= 1'b0;
      O_mem_we    <= 1'b0;
      O_mem_addr  <= '0;
      O_mem_wdata <= '0;
      O_mem_be    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|I_grant) begin
            r_idx       <= w_idx;
            O_mem_addr  <= I_addr[w_idx*AW +: AW];
            O_mem_we    <= I_we[w_idx];
            O_mem_wdata <= I_wdata[w_idx*DW +: DW];
            O_mem_be    <= I_be[w_idx*c_bw +: c_bw];
            O_mem_req   <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (I_mem_ready) begin
            O_mem_req <= 1'b0;
            r_cnt     <= '0;
            if (O_mem_we) begin
              O_ack   <= w_hot;
              O_err   <= 1'b0;
              r_state <= ST_ACK;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A response landing on the timeout cycle still counts as success.
          if (I_mem_valid) begin
            O_rdata <= I_mem_rdata;
            O_ack   <= w_hot;
            O_err   <= 1'b0;
            r_state <= ST_ACK;
          end else if (w_timeout) begin
            O_rdata <= '0;
            O_ack   <= w_hot;
            O_err   <= 1'b1;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_ACK: begin
          O_ack   <= '0;
          O_err   <= 1'b0;
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c5_mem_mux.sv
`default_nettype none
// ============================================================================
// tb_c5_mem_mux : directed and randomized transactions against a cycle-level
//                 reference of the grant/issue/wait/ack/release sequence.
// Revision      : 1.0
// ============================================================================
module tb_c5_mem_mux;

  localparam int W  = 6;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    grant_drv, arb_grant, dut_grant;
  logic            use_arb;
  logic [W-1:0]    req;
  int              last_arb;
  logic [W*AW-1:0] addr;
  logic [W-1:0]    we;
  logic [W*DW-1:0] wdata;
  logic [W*4-1:0]  be;
  logic            stall, err, mem_req, mem_we, mem_ready, mem_valid;
  logic [W-1:0]    ack;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic [3:0]      mem_be;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_rdata;

  assign dut_grant = use_arb ? arb_grant : grant_drv;

  c5_mem_mux #(.WIDTH(W), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .I_clk(clk), .I_rst(rst), .I_grant(dut_grant), .O_stall(stall),
    .I_addr(addr), .I_we(we), .I_wdata(wdata), .I_be(be),
    .O_ack(ack), .O_err(err), .O_rdata(rdata),
    .O_mem_req(mem_req), .O_mem_we(mem_we), .O_mem_addr(mem_addr),
    .O_mem_wdata(mem_wdata), .O_mem_be(mem_be),
    .I_mem_ready(mem_ready), .I_mem_valid(mem_valid), .I_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [W-1:0] g);
    for (int i = 0; i < W; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] rr_pick(input logic [W-1:0] r, input int last);
    for (int off = 1; off <= W; off++) begin
      int j;
      j = (last + off) % W;
      if (r[j]) return W'(1) << j;
    end
    return '0;
  endfunction

  // Round-robin arbiter stand-in: re-decides only while the mux is not stalling.
  always @(posedge clk) begin
    if (rst || !use_arb) begin
      arb_grant <= '0;
      last_arb  <= W - 1;
    end else if (!stall) begin
      arb_grant <= rr_pick(req, last_arb);
      if (rr_pick(req, last_arb) != '0) last_arb <= lowest(rr_pick(req, last_arb));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_clients();
    for (int i = 0; i < W; i++) begin
      addr[i*AW +: AW] = AW'($urandom);
      wdata[i*DW +: DW] = $urandom;
      be[i*4 +: 4]     = 4'($urandom);
    end
    we = W'($urandom);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one transaction from IDLE back to IDLE; caller has set up the client inputs.
  task automatic txn(input logic [W-1:0] g, input bit w, input int rdy, input int vld,
                     input logic [DW-1:0] rd);
    int idx, n;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, rv;
    logic [3:0]    e_be;
    bit            e_err;
    idx = lowest(g);
    we[idx] = w;
    e_addr = addr[idx*AW +: AW];
    e_wdata = wdata[idx*DW +: DW];
    e_be = be[idx*4 +: 4];
    grant_drv = g;
    #1;
    chk("stall_c0", stall, 1);
    cyc();
    rand_clients();
    for (int k = 0; k <= rdy; k++) begin
      chk("issue_req", mem_req, 1);
      chk("issue_we", mem_we, w);
      chk("issue_addr", mem_addr, e_addr);
      chk("issue_wdata", mem_wdata, e_wdata);
      chk("issue_be", mem_be, e_be);
      chk("issue_stall", stall, 1);
      chk("issue_ack", ack, 0);
      mem_ready = (k == rdy);
      cyc();
    end
    mem_ready = 1'b0;
    e_err = 1'b0;
    if (!w) begin
      n = (vld < TO) ? vld : TO - 1;
      rv = '0;
      for (int k = 0; k <= n; k++) begin
        chk("wait_req", mem_req, 0);
        chk("wait_stall", stall, 1);
        chk("wait_ack", ack, 0);
        mem_valid = (k == vld);
        mem_rdata = (k == vld) ? rd : $urandom;
        cyc();
      end
      mem_valid = 1'b0;
      e_err = (vld >= TO);
      model_rdata = e_err ? '0 : rd;
    end
    chk("ack_vec", ack, W'(1) << idx);
    chk("ack_err", err, e_err);
    chk("ack_rdata", rdata, model_rdata);
    chk("ack_stall", stall, 1);
    grant_drv = W'($urandom_range(1, 63));
    cyc();
    chk("rel_ack", ack, 0);
    chk("rel_err", err, 0);
    chk("rel_stall", stall, 0);
    grant_drv = '0;
    cyc();
    chk("idle_req", mem_req, 0);
    chk("idle_stall", stall, 0);
    chk("idle_ack", ack, 0);
  endtask

  initial begin
    int nacks, budget;
    logic [W-1:0] prev_ack;
    rst = 1'b1; use_arb = 1'b0; grant_drv = '0; req = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    model_rdata = '0;
    rand_clients();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_cmd", {mem_we, mem_addr, mem_wdata, mem_be}, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    cyc();

    // Directed write from client 2
    rand_clients();
    addr[2*AW +: AW] = 24'h001234;
    wdata[2*DW +: DW] = 32'hDEADBEEF;
    be[2*4 +: 4] = 4'hF;
    txn(6'b000100, 1'b1, 0, 0, '0);

    // Directed read from client 0, response 5 cycles into WAIT
    rand_clients();
    txn(6'b000001, 1'b0, 0, 5, 32'hCAFEF00D);

    // Ready back-pressure for 3 cycles
    rand_clients();
    txn(6'b001000, 1'b1, 3, 0, '0);

    // Multi-hot grant resolves to the lowest index
    rand_clients();
    txn(6'b101010, 1'b0, 1, 2, $urandom);

    // Response on the timeout cycle wins
    rand_clients();
    txn(6'b010000, 1'b0, 0, TO - 1, $urandom);

    // Timeout, then a late response while idle
    rand_clients();
    txn(6'b100000, 1'b0, 0, TO + 2, $urandom);
    mem_valid = 1'b1;
    mem_rdata = $urandom;
    cyc();
    mem_valid = 1'b0;
    chk("late_ack", ack, 0);
    chk("late_req", mem_req, 0);
    chk("late_stall", stall, 0);
    chk("late_rdata", rdata, model_rdata);

    for (int t = 0; t < 24; t++) begin
      rand_clients();
      txn(W'($urandom_range(1, 63)), 1'($urandom), $urandom_range(0, 3),
          $urandom_range(0, TO + 1), $urandom);
    end

    // Reset while waiting for a read response
    rand_clients();
    we[3] = 1'b0;
    grant_drv = 6'b001000;
    cyc();
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    grant_drv = '0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = $urandom;
    cyc();
    mem_valid = 1'b0;
    model_rdata = '0;
    chk("rstw_ack", ack, 0);
    chk("rstw_err", err, 0);
    chk("rstw_rdata", rdata, 0);
    chk("rstw_req", mem_req, 0);
    chk("rstw_cmd", {mem_we, mem_addr, mem_wdata, mem_be}, 0);
    chk("rstw_stall", stall, 0);
    cyc();
    chk("rstw_ack2", ack, 0);

    // Arbiter-driven: clients 1 and 4 writing continuously
    we = '1;
    mem_ready = 1'b1;
    req = 6'b010010;
    use_arb = 1'b1;
    nacks = 0;
    budget = 0;
    prev_ack = '0;
    while (nacks < 8 && budget < 200) begin
      cyc();
      budget++;
      if (ack != '0) begin
        chk("arb_onehot", $onehot(ack), 1);
        chk("arb_owner", ack, arb_grant);
        chk("arb_seq", lowest(ack), (nacks % 2 == 0) ? 1 : 4);
        chk("arb_double", ack & prev_ack, 0);
        nacks++;
      end
      prev_ack = ack;
      req = 6'b010010 & ~ack;
    end
    chk("arb_count", nacks, 8);
    use_arb = 1'b0;
    mem_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
